// File: rtl/instruction_fetch_unit.sv
// Fetch stage: program counter, three-state fetch FSM and instruction register.
// Optional build macro FETCH_PERF_CNT_EN enables the completed-fetch counter on fetch_count.
module instruction_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_addr,
  output logic [ADDR_W-1:0] inst_address,
  input  logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  output logic              busy,
  output logic [31:0]       fetch_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [DATA_W-1:0] ir_reg;
  logic [ADDR_W-1:0] ir_pc_reg;
  logic              ir_valid_reg;
  logic              capture;

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE:    if (fetch_req) state_next = ADDR;
      ADDR:    state_next = pc_load ? IDLE : LATCH;
      LATCH: begin
        state_next = IDLE;
        // A redirect arriving in the capture cycle discards the fetched word.
        capture    = !pc_load;
      end
      default: state_next = IDLE;
    endcase

    pc_next = pc_reg;
    if (pc_load)
      pc_next = pc_load_addr;
    else if (capture)
      pc_next = pc_reg + ADDR_W'(PC_STEP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_PC;
      ir_reg       <= '0;
      ir_pc_reg    <= '0;
      ir_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      ir_valid_reg <= capture;
      if (capture) begin
        ir_reg    <= read_data;
        ir_pc_reg <= pc_reg;
      end
    end
  end

  assign inst_address = pc_reg;
  assign ir           = ir_reg;
  assign ir_pc        = ir_pc_reg;
  assign ir_valid     = ir_valid_reg;
  assign busy         = (state_reg != IDLE);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count_reg <= '0;
    else if (capture)
      count_reg <= count_reg + 32'd1;
  end

  assign fetch_count = count_reg;
`else
  assign fetch_count = 32'h0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vector table, hand-written corner sequences,
// and randomized traffic against a transaction-level model of the fetch stage.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic        pc_load = 1'b0;
  logic [15:0] pc_load_addr = 16'h0;
  logic [15:0] inst_address;
  logic [31:0] read_data;
  logic [31:0] ir;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        busy;
  logic [31:0] fetch_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Instruction memory: word = {A5A5, address}
  assign read_data = {16'hA5A5, inst_address};

  instruction_fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_req    (fetch_req),
    .pc_load      (pc_load),
    .pc_load_addr (pc_load_addr),
    .inst_address (inst_address),
    .read_data    (read_data),
    .ir           (ir),
    .ir_pc        (ir_pc),
    .ir_valid     (ir_valid),
    .busy         (busy),
    .fetch_count  (fetch_count)
  );

  typedef struct {
    logic        req;
    logic        ld;
    logic [15:0] addr;
    logic        valid;
    logic        busy;
    logic [31:0] ir;
    logic [15:0] ir_pc;
    logic [15:0] pc;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[24];

  // Transaction-level model: an outstanding fetch is described by its age in cycles.
  logic [15:0] m_pc;
  logic [31:0] m_ir;
  logic [15:0] m_ir_pc;
  logic        m_valid;
  int          m_age;
  logic [31:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input logic [31:0] c);
`ifdef FETCH_PERF_CNT_EN
    return c;
`else
    return 32'h0 & c;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc = 16'h0; m_ir = 32'h0; m_ir_pc = 16'h0; m_valid = 1'b0; m_age = 0; m_cnt = 32'h0;
  endtask

  task automatic model_step(input logic req, input logic ld, input logic [15:0] addr);
    m_valid = 1'b0;
    if (m_age == 0) begin
      if (ld) m_pc = addr;
      if (req) m_age = 1;
    end else if (ld) begin
      m_pc  = addr;
      m_age = 0;
    end else if (m_age == 1) begin
      m_age = 2;
    end else begin
      m_ir    = {16'hA5A5, m_pc};
      m_ir_pc = m_pc;
      m_pc    = m_pc + 16'd1;
      m_valid = 1'b1;
      m_cnt   = m_cnt + 32'd1;
      m_age   = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    fetch_req = 1'b0; pc_load = 1'b0; pc_load_addr = 16'h0;
    tick(); tick();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic chk_all(input string tag, input logic v, input logic b, input logic [31:0] i,
                         input logic [15:0] ip, input logic [15:0] p, input logic [31:0] c);
    chk({tag, ".ir_valid"},     {31'h0, ir_valid}, {31'h0, v});
    chk({tag, ".busy"},         {31'h0, busy},     {31'h0, b});
    chk({tag, ".ir"},           ir,                i);
    chk({tag, ".ir_pc"},        {16'h0, ir_pc},    {16'h0, ip});
    chk({tag, ".inst_address"}, {16'h0, inst_address}, {16'h0, p});
    chk({tag, ".fetch_count"},  fetch_count,       cnt_exp(c));
  endtask

  initial begin
    // req ld addr | valid busy ir ir_pc pc cnt
    vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 32'h00000000, 16'h0000, 16'h0000, 32'd0};
    vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 32'h00000000, 16'h0000, 16'h0000, 32'd0};
    vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 32'hA5A50000, 16'h0000, 16'h0001, 32'd1};
    vecs[3]  = '{1'b1, 1'b1, 16'h0040, 1'b0, 1'b1, 32'hA5A50000, 16'h0000, 16'h0040, 32'd1};
    vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 32'hA5A50000, 16'h0000, 16'h0040, 32'd1};
    vecs[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 32'hA5A50040, 16'h0040, 16'h0041, 32'd2};
    vecs[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 32'hA5A50040, 16'h0040, 16'h0041, 32'd2};
    vecs[7]  = '{1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 32'hA5A50040, 16'h0040, 16'h0100, 32'd2};
    vecs[8]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 32'hA5A50040, 16'h0040, 16'h0100, 32'd2};
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 32'hA5A50040, 16'h0040, 16'h0100, 32'd2};
    vecs[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 32'hA5A50100, 16'h0100, 16'h0101, 32'd3};
    vecs[11] = '{1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b1, 32'hA5A50100, 16'h0100, 16'hFFFF, 32'd3};
    vecs[12] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 32'hA5A50100, 16'h0100, 16'hFFFF, 32'd3};
    vecs[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 32'hA5A5FFFF, 16'hFFFF, 16'h0000, 32'd4};
    vecs[14] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 32'hA5A5FFFF, 16'hFFFF, 16'h0000, 32'd4};
    vecs[15] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 32'hA5A5FFFF, 16'hFFFF, 16'h0000, 32'd4};
    vecs[16] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 32'hA5A50000, 16'h0000, 16'h0001, 32'd5};
    vecs[17] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 32'hA5A50000, 16'h0000, 16'h0001, 32'd5};
    vecs[18] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 32'hA5A50000, 16'h0000, 16'h0001, 32'd5};
    vecs[19] = '{1'b0, 1'b1, 16'h0200, 1'b0, 1'b0, 32'hA5A50000, 16'h0000, 16'h0200, 32'd5};
    vecs[20] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 32'hA5A50000, 16'h0000, 16'h0200, 32'd5};
    vecs[21] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 32'hA5A50000, 16'h0000, 16'h0200, 32'd5};
    vecs[22] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 32'hA5A50200, 16'h0200, 16'h0201, 32'd6};
    vecs[23] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 32'hA5A50200, 16'h0200, 16'h0201, 32'd6};

    // Reset state
    do_reset();
    chk_all("reset", 1'b0, 1'b0, 32'h0, 16'h0, 16'h0, 32'd0);
    $display("reset: pc=%h ir=%h busy=%b", inst_address, ir, busy);

    // Directed table: redirect, abort in ADDR and LATCH, wrap, ignored request
    for (int i = 0; i < 24; i++) begin
      fetch_req = vecs[i].req; pc_load = vecs[i].ld; pc_load_addr = vecs[i].addr;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].valid, vecs[i].busy, vecs[i].ir,
              vecs[i].ir_pc, vecs[i].pc, vecs[i].cnt);
      $display("vec%0d: req=%b ld=%b addr=%h -> valid=%b busy=%b ir=%h ir_pc=%h pc=%h cnt=%0d",
               i, vecs[i].req, vecs[i].ld, vecs[i].addr, ir_valid, busy, ir, ir_pc,
               inst_address, fetch_count);
    end
    fetch_req = 1'b0; pc_load = 1'b0;

    // Sequential back-to-back fetches with fetch_req held high
    do_reset();
    fetch_req = 1'b1;
    for (int k = 1; k <= 27; k++) begin
      tick();
      chk($sformatf("seq%0d.ir_valid", k), {31'h0, ir_valid}, {31'h0, (k % 3) == 0});
      if ((k % 3) == 0) begin
        chk($sformatf("seq%0d.ir", k), ir, {16'hA5A5, 16'(k / 3 - 1)});
        chk($sformatf("seq%0d.ir_pc", k), {16'h0, ir_pc}, {16'h0, 16'(k / 3 - 1)});
        $display("seq fetch %0d: ir=%h ir_pc=%h", k / 3, ir, ir_pc);
      end
    end
    fetch_req = 1'b0;
    chk("seq.final_pc", {16'h0, inst_address}, 32'h9);
    chk("seq.fetch_count", fetch_count, cnt_exp(32'd9));

    // Asynchronous reset mid-fetch, then idle with no requests
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk_all("midreset", 1'b0, 1'b0, 32'h0, 16'h0, 16'h0, 32'd0);
    $display("midreset: pc=%h ir=%h valid=%b busy=%b", inst_address, ir, ir_valid, busy);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_all($sformatf("idle%0d", k), 1'b0, 1'b0, 32'h0, 16'h0, 16'h0, 32'd0);
    end

    // Randomized traffic against the model
    do_reset();
    model_reset();
    for (int n = 0; n < 400; n++) begin
      fetch_req    = ($urandom_range(0, 1) == 1);
      pc_load      = ($urandom_range(0, 5) == 0);
      pc_load_addr = 16'($urandom);
      model_step(fetch_req, pc_load, pc_load_addr);
      tick();
      chk_all($sformatf("rnd%0d", n), m_valid, (m_age != 0), m_ir, m_ir_pc, m_pc, m_cnt);
      $display("rnd%0d: req=%b ld=%b addr=%h -> valid=%b busy=%b ir=%h pc=%h",
               n, fetch_req, pc_load, pc_load_addr, ir_valid, busy, ir, inst_address);
    end
    fetch_req = 1'b0; pc_load = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
